// File: rtl/ctrl_pipe_arbiter_pkg.sv
// Shared types for the control-pipe arbiter: the functional-unit packet,
// the per-lane holding slot and the active-list age helper.
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 7
`endif

package ctrl_pipe_arbiter_pkg;

    localparam int AL_LOG_W = `SIZE_ACTIVELIST_LOG;

    typedef struct packed {
        logic                valid;
        logic                isCSR;
        logic [AL_LOG_W-1:0] alID;
        logic [7:0]          opcode;
    } fuPkt;

    typedef struct packed {
        fuPkt pkt;
        logic valid;
    } ctrlArbSlot_t;

    // Distance from the active-list head; modular subtraction handles wrap.
    function automatic logic [AL_LOG_W-1:0] alAge(
        input logic [AL_LOG_W-1:0] alID,
        input logic [AL_LOG_W-1:0] head
    );
        return alID - head;
    endfunction

endpackage

// File: rtl/ctrl_age_picker.sv
// Combinational minimum-age picker over NUM_REQ candidates.
// Ties resolve to the lowest index.
module ctrl_age_picker
    import ctrl_pipe_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AL_LOG  = AL_LOG_W
) (
    input  logic [NUM_REQ-1:0]             elig_i,
    input  logic [NUM_REQ-1:0][AL_LOG-1:0] age_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           found_o
);

    logic [AL_LOG-1:0] bestAge;

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        bestAge = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Strict compare keeps the earlier index on equal ages.
            if (elig_i[i] && (!found_o || age_i[i] < bestAge)) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                found_o    = 1'b1;
                bestAge    = age_i[i];
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe_arbiter.sv
// Shares the control execute lane between NUM_REQ issue lanes, issuing the
// oldest eligible packet and holding CSRs until they reach the list head.
module ctrl_pipe_arbiter
    import ctrl_pipe_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AL_LOG  = AL_LOG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  fuPkt [NUM_REQ-1:0]     reqPkt_i,
    input  logic [NUM_REQ-1:0]     reqValid_i,
    output logic [NUM_REQ-1:0]     reqReady_o,
    input  logic [AL_LOG-1:0]      alHead_i,
    input  logic                   flush_i,
    input  logic                   exeStall_i,
    output fuPkt                   exePacket_o,
    output logic                   exeValid_o,
    output logic                   csrPending_o
);

    ctrlArbSlot_t [NUM_REQ-1:0]             slot_q;
    ctrlArbSlot_t [NUM_REQ-1:0]             slot_d;
    fuPkt                                   exePkt_q;
    fuPkt                                   exePkt_d;
    logic                                   exeValid_q;
    logic                                   exeValid_d;

    logic [NUM_REQ-1:0]                     eligible;
    logic [NUM_REQ-1:0]                     csrWait;
    logic [NUM_REQ-1:0][AL_LOG-1:0]         age;
    logic [NUM_REQ-1:0]                     pick;
    logic [NUM_REQ-1:0]                     grant;
    logic [NUM_REQ-1:0]                     accept;
    logic                                   found;
    logic                                   load;
    fuPkt                                   winPkt;

    always_comb begin
        eligible = '0;
        csrWait  = '0;
        age      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age[i]      = alAge(slot_q[i].pkt.alID, alHead_i);
            csrWait[i]  = slot_q[i].valid & slot_q[i].pkt.isCSR &
                          (slot_q[i].pkt.alID != alHead_i);
            eligible[i] = slot_q[i].valid & ~csrWait[i];
        end
    end

    ctrl_age_picker #(
        .NUM_REQ (NUM_REQ),
        .AL_LOG  (AL_LOG)
    ) u_picker (
        .elig_i  (eligible),
        .age_i   (age),
        .grant_o (pick),
        .found_o (found)
    );

    // A stalled live output blocks all grants so the lane sees a stable packet.
    assign load  = ~exeValid_q | ~exeStall_i;
    assign grant = load ? pick : '0;

    always_comb begin
        winPkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                winPkt = slot_q[i].pkt;
            end
        end
        winPkt.valid = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqReady_o[i] = (~slot_q[i].valid | grant[i]) & ~flush_i & ~reset;
        end
    end

    assign accept = reqValid_i & reqReady_o;

    always_comb begin
        slot_d     = slot_q;
        exePkt_d   = exePkt_q;
        exeValid_d = exeValid_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot_d[i].pkt   = reqPkt_i[i];
                slot_d[i].valid = 1'b1;
            end else if (grant[i]) begin
                slot_d[i].valid = 1'b0;
            end
        end
        if (load) begin
            exeValid_d = found;
            if (found) begin
                exePkt_d = winPkt;
            end
        end
        if (flush_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_d[i].valid = 1'b0;
            end
            exeValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q     <= '0;
            exePkt_q   <= '0;
            exeValid_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            exePkt_q   <= exePkt_d;
            exeValid_q <= exeValid_d;
        end
    end

    assign exePacket_o  = exePkt_q;
    assign exeValid_o   = exeValid_q;
    assign csrPending_o = |csrWait;

endmodule

// File: tb/tb_ctrl_pipe_arbiter.sv
// Directed-vector bench for ctrl_pipe_arbiter with hand-computed expectations.
module tb_ctrl_pipe_arbiter;
    import ctrl_pipe_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    fuPkt [1:0]       reqPkt;
    logic [1:0]       reqValid;
    logic [1:0]       reqReady;
    logic [6:0]       alHead;
    logic             flush;
    logic             exeStall;
    fuPkt             exePacket;
    logic             exeValid;
    logic             csrPending;

    int errors = 0;
    int checks = 0;
    fuPkt held;

    ctrl_pipe_arbiter #(.NUM_REQ(2), .AL_LOG(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .reqPkt_i     (reqPkt),
        .reqValid_i   (reqValid),
        .reqReady_o   (reqReady),
        .alHead_i     (alHead),
        .flush_i      (flush),
        .exeStall_i   (exeStall),
        .exePacket_o  (exePacket),
        .exeValid_o   (exeValid),
        .csrPending_o (csrPending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic fuPkt mk(input logic csr, input logic [6:0] id,
                                input logic [7:0] op, input logic v);
        fuPkt p;
        p.valid  = v;
        p.isCSR  = csr;
        p.alID   = id;
        p.opcode = op;
        return p;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        reqPkt   = '0;
        reqValid = '0;
        alHead   = 7'd0;
        flush    = 1'b0;
        exeStall = 1'b0;
        settle();
        chk("rst_ready", reqReady, 2'b00);
        tick();
        tick();
        chk("rst_valid", exeValid, 1'b0);
        chk("rst_pkt", exePacket, '0);
        chk("rst_csr", csrPending, 1'b0);
        reset = 1'b0;
        settle();
        chk("post_rst_ready", reqReady, 2'b11);

        // single lane latency
        alHead = 7'd5;
        reqPkt[0] = mk(1'b0, 7'd5, 8'h11, 1'b0);
        reqValid = 2'b01;
        settle();
        chk("single_ready", reqReady, 2'b11);
        tick();
        reqValid = 2'b00;
        settle();
        chk("single_c1", exeValid, 1'b0);
        tick();
        chk("single_c2_v", exeValid, 1'b1);
        chk("single_c2_pkt", exePacket, mk(1'b0, 7'd5, 8'h11, 1'b1));
        tick();
        chk("single_c3_v", exeValid, 1'b0);

        // age with wrap: head 120, alID 3 is age 11, alID 125 is age 5
        alHead = 7'd120;
        reqPkt[0] = mk(1'b0, 7'd3, 8'h20, 1'b0);
        reqPkt[1] = mk(1'b0, 7'd125, 8'h21, 1'b0);
        reqValid = 2'b11;
        tick();
        reqValid = 2'b00;
        tick();
        chk("wrap_first", exePacket, mk(1'b0, 7'd125, 8'h21, 1'b1));
        chk("wrap_first_v", exeValid, 1'b1);
        tick();
        chk("wrap_second", exePacket, mk(1'b0, 7'd3, 8'h20, 1'b1));
        chk("wrap_second_v", exeValid, 1'b1);
        tick();
        chk("wrap_done", exeValid, 1'b0);

        // CSR hold until head
        alHead = 7'd8;
        reqPkt[0] = mk(1'b1, 7'd10, 8'h30, 1'b0);
        reqPkt[1] = mk(1'b0, 7'd12, 8'h31, 1'b0);
        reqValid = 2'b11;
        tick();
        reqValid = 2'b00;
        settle();
        chk("csr_pend_c1", csrPending, 1'b1);
        tick();
        chk("csr_bypass", exePacket, mk(1'b0, 7'd12, 8'h31, 1'b1));
        chk("csr_pend_c2", csrPending, 1'b1);
        tick();
        chk("csr_blocked", exeValid, 1'b0);
        chk("csr_ready", reqReady, 2'b10);
        alHead = 7'd10;
        settle();
        chk("csr_pend_head", csrPending, 1'b0);
        tick();
        chk("csr_issue", exePacket, mk(1'b1, 7'd10, 8'h30, 1'b1));
        chk("csr_issue_v", exeValid, 1'b1);
        tick();
        chk("csr_done", exeValid, 1'b0);

        // stall with both slots full
        alHead = 7'd20;
        reqPkt[0] = mk(1'b0, 7'd21, 8'h40, 1'b0);
        reqPkt[1] = mk(1'b0, 7'd22, 8'h41, 1'b0);
        reqValid = 2'b11;
        tick();
        reqPkt[0] = mk(1'b0, 7'd23, 8'h42, 1'b0);
        reqValid = 2'b01;
        settle();
        chk("refill_ready", reqReady, 2'b01);
        tick();
        reqValid = 2'b00;
        exeStall = 1'b1;
        settle();
        chk("stall_pkt0", exePacket, mk(1'b0, 7'd21, 8'h40, 1'b1));
        held = exePacket;
        for (int c = 0; c < 3; c++) begin
            chk("stall_ready", reqReady, 2'b00);
            tick();
            chk("stall_stable", exePacket, held);
            chk("stall_valid", exeValid, 1'b1);
        end
        exeStall = 1'b0;
        tick();
        chk("unstall_b", exePacket, mk(1'b0, 7'd22, 8'h41, 1'b1));
        chk("unstall_b_v", exeValid, 1'b1);
        tick();
        chk("unstall_c", exePacket, mk(1'b0, 7'd23, 8'h42, 1'b1));
        chk("unstall_c_v", exeValid, 1'b1);
        tick();
        chk("unstall_done", exeValid, 1'b0);

        // flush mid-operation
        alHead = 7'd30;
        reqPkt[0] = mk(1'b0, 7'd31, 8'h50, 1'b0);
        reqPkt[1] = mk(1'b0, 7'd32, 8'h51, 1'b0);
        reqValid = 2'b11;
        tick();
        reqPkt[0] = mk(1'b0, 7'd33, 8'h52, 1'b0);
        reqValid = 2'b01;
        tick();
        chk("flush_pre_v", exeValid, 1'b1);
        reqPkt[0] = mk(1'b0, 7'd34, 8'h53, 1'b0);
        reqValid = 2'b01;
        flush = 1'b1;
        exeStall = 1'b1;
        settle();
        chk("flush_ready", reqReady, 2'b00);
        tick();
        flush = 1'b0;
        exeStall = 1'b0;
        reqValid = 2'b00;
        settle();
        chk("flush_v", exeValid, 1'b0);
        chk("flush_empty", reqReady, 2'b11);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("flush_no_issue", exeValid, 1'b0);
        end

        // reset mid-stream
        alHead = 7'd40;
        reqPkt[0] = mk(1'b1, 7'd45, 8'h60, 1'b0);
        reqPkt[1] = mk(1'b0, 7'd42, 8'h61, 1'b0);
        reqValid = 2'b11;
        tick();
        reqPkt[1] = mk(1'b0, 7'd43, 8'h62, 1'b0);
        reqValid = 2'b10;
        tick();
        chk("rst2_pre_v", exeValid, 1'b1);
        reqPkt[1] = mk(1'b0, 7'd44, 8'h63, 1'b0);
        reqValid = 2'b11;
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        reqValid = 2'b00;
        settle();
        chk("rst2_v", exeValid, 1'b0);
        chk("rst2_pkt", exePacket, '0);
        chk("rst2_csr", csrPending, 1'b0);
        chk("rst2_ready", reqReady, 2'b11);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst2_no_issue", exeValid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
